discrete_gated_tone_mixer: RTL and testbench
============================================

Name: discrete_gated_tone_mixer

Overview:
- Parametrised, multi-channel successor to the single-channel gated sound-effect generators (walk/jump class).
- Each channel is a square-wave tone with its own phase accumulator, frequency word and gate input.
- Each gate drives an RC-like one-pole attack/release envelope.
- Channels are mixed into one signed sample on the audio_clk_en strobe, ready for the audio mixer.

Parameters:
- CLOCK_RATE, 48000000, system clock in Hz; documentation and bench timing only.
- SAMPLE_RATE, 48000, audio_clk_en rate in Hz.
- CHANNELS, 2, number of tone channels, 1..8.
- OUT_WIDTH, 16, output sample width, signed.
- ATTACK_SHIFT, 6, attack coefficient: env += (32767-env)>>>ATTACK_SHIFT per sample.
- RELEASE_SHIFT, 8, release coefficient: env -= env>>>RELEASE_SHIFT per sample.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- audio_clk_en  in  1  one-clk sample strobe at SAMPLE_RATE.
- gate  in  CHANNELS  per-channel enable, level-sensitive.
- freq_inc  in  16*CHANNELS  per-channel phase increment; channel k uses bits [16k+15:16k].
- active  out  CHANNELS  channel k's envelope is non-zero, or its state is not IDLE.
- out  out  OUT_WIDTH (signed)  mixed sample.
- out_valid  out  1  one-clk pulse when out updates.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: out=0, out_valid=0, active=0.
  - Every channel: env=0, phase=0, state IDLE. Release is immediate, including mid-attack.
- All state advances only on clk edges where audio_clk_en=1 (a "tick"). Between ticks, all state holds.
- Inputs gate and freq_inc are sampled on the tick edge.
- Per-channel FSM, evaluated on each tick:
  - IDLE: gate=1 -> ATTACK. Otherwise stays; env stays 0.
  - ATTACK: gate=0 -> RELEASE. Otherwise env += (32767-env)>>>ATTACK_SHIFT. If that step is 0, env snaps to 32767 -> HOLD.
  - HOLD: env=32767. gate=0 -> RELEASE.
  - RELEASE: gate=1 -> ATTACK, retriggering from the current env with no reset to 0. Otherwise env -= env>>>RELEASE_SHIFT. If that step is 0, env snaps to 0 -> IDLE.
  - The state change and the env update for the new state happen on the same tick as the gate change. Example: the IDLE->ATTACK tick already adds the first attack step.
- Oscillator:
  - Sample s_k = phase[15] ? -env : +env, using phase and env from before the tick update (17-bit signed).
  - Then phase += freq_inc, mod 2^16 (wrap-around intended).
  - freq_inc=0 holds phase. The output is then DC at ±env.
- Mix: sum of all s_k in 17+clog2(CHANNELS) bits. Scaling per Optional Feature. Result truncated to OUT_WIDTH by taking the MSBs aligned to bit 15.
- Latency:
  - out and out_valid are registered on the clk edge following the tick edge. That is 1 clk after audio_clk_en is sampled high.
  - out_valid is high for exactly 1 clk. out holds between updates.
- active[k]=1 iff channel k is not IDLE. It is registered with the FSM.
- Back-to-back ticks (audio_clk_en high on consecutive clks) are legal. Each one advances one sample.

Optional Feature:
- Macro: DISCRETE_MIX_SATURATE_EN.
- Defined: sum is clamped to [-32767, +32767] with no shift, so loud channels clip like the original analogue mixer.
- Undefined: sum is arithmetic-shifted right by clog2(CHANNELS), so overflow can never occur.
- For CHANNELS=1 both modes give identical output.

Test Plan:
1. Reset: hold rst_n=0 with gate=all-1 and 5 ticks -> out=0, out_valid never pulses, active=0. Release rst_n; the first tick gives out=0 (env was 0 before the update).
2. Attack/hold, CHANNELS=1, ATTACK_SHIFT=1, freq_inc=0, gate=1 -> env sequence 16383, 24575, 28671 ...; reaches 32767, state HOLD. out equals the previous tick's env, positive.
3. Square wave, freq_inc=0x4000, channel in HOLD -> out pattern +32767, +32767, -32767, -32767, repeating every 4 ticks.
4. Release and retrigger, RELEASE_SHIFT=1: gate drops at env=32767 -> env 16384, 8192, ... down to 0, then active=0. Raise gate at env=8192 -> next env = 8192+(24575>>>1) = 20479.
5. Mix, CHANNELS=2, both in HOLD, freq_inc=0 -> saturate build: out=+32767; non-saturate build: out=+32767 (65534>>>1). One channel at phase[15]=1 -> out=0.
6. Timing: audio_clk_en on 3 consecutive clks -> 3 out_valid pulses, each 1 clk late. Pull rst_n low mid-attack -> out=0 and env=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/discrete_gated_tone_mixer.sv
// discrete_gated_tone_mixer
// Multi-channel gated square-wave tone generator with per-channel one-pole
// attack/release envelopes, mixed into one signed sample per audio_clk_en tick.
// Optional build macro: DISCRETE_MIX_SATURATE_EN
//   defined   -> mixed sum is clamped to [-32767, +32767] without scaling
//   undefined -> mixed sum is arithmetic-shifted right by clog2(CHANNELS)
module discrete_gated_tone_mixer #(
    parameter int CLOCK_RATE    = 48000000,
    parameter int SAMPLE_RATE   = 48000,
    parameter int CHANNELS      = 2,
    parameter int OUT_WIDTH     = 16,
    parameter int ATTACK_SHIFT  = 6,
    parameter int RELEASE_SHIFT = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        audio_clk_en,
    input  logic [CHANNELS-1:0]         gate,
    input  logic [16*CHANNELS-1:0]      freq_inc,
    output logic [CHANNELS-1:0]         active,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        out_valid
);

    localparam int          LOG2_CH = $clog2(CHANNELS);
    localparam int          SUM_W   = 17 + LOG2_CH;
    localparam logic [15:0] ENV_MAX = 16'd32767;

    // Parameter sanity: the sample strobe is derived from the system clock.
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("discrete_gated_tone_mixer: CHANNELS must be 1..8");
    end
    if (SAMPLE_RATE <= 0 || SAMPLE_RATE > CLOCK_RATE) begin : g_bad_rates
        $error("discrete_gated_tone_mixer: SAMPLE_RATE must be 1..CLOCK_RATE");
    end

    typedef enum logic [1:0] {IDLE, ATTACK, HOLD, RELEASE} state_t;

    state_t                  state_q   [CHANNELS];
    state_t                  state_d   [CHANNELS];
    logic [15:0]             env_q     [CHANNELS];
    logic [15:0]             env_d     [CHANNELS];
    logic [15:0]             phase_q   [CHANNELS];
    logic [15:0]             att_step  [CHANNELS];
    logic [15:0]             rel_step  [CHANNELS];
    logic signed [16:0]      sample    [CHANNELS];
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;
    logic                    sum_valid;
    logic signed [15:0]      scaled;
    logic signed [OUT_WIDTH-1:0] out_d;

    // Per-channel envelope FSM next state and the pre-update oscillator sample.
    // NOTE: every output of this block gets a value on every path so no latch is inferred.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            att_step[k] = (ENV_MAX - env_q[k]) >> ATTACK_SHIFT;
            rel_step[k] = env_q[k] >> RELEASE_SHIFT;
            state_d[k]  = state_q[k];
            env_d[k]    = env_q[k];
            if (gate[k]) begin
                case (state_q[k])
                    HOLD: begin
                        state_d[k] = HOLD;
                        env_d[k]   = ENV_MAX;
                    end
                    default: begin
                        // IDLE, ATTACK and RELEASE all climb from the current env;
                        // a zero step means the curve has converged.
                        if (att_step[k] == 16'd0) begin
                            state_d[k] = HOLD;
                            env_d[k]   = ENV_MAX;
                        end else begin
                            state_d[k] = ATTACK;
                            env_d[k]   = env_q[k] + att_step[k];
                        end
                    end
                endcase
            end else begin
                case (state_q[k])
                    IDLE: begin
                        state_d[k] = IDLE;
                        env_d[k]   = '0;
                    end
                    default: begin
                        if (rel_step[k] == 16'd0) begin
                            state_d[k] = IDLE;
                            env_d[k]   = '0;
                        end else begin
                            state_d[k] = RELEASE;
                            env_d[k]   = env_q[k] - rel_step[k];
                        end
                    end
                endcase
            end
            sample[k] = phase_q[k][15] ? -$signed({1'b0, env_q[k]})
                                       :  $signed({1'b0, env_q[k]});
            active[k] = (state_q[k] != IDLE);
        end
    end

    // Sum of all channel samples at full precision.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_d = sum_d + SUM_W'(sample[k]);
        end
    end

    // Scale the registered sum back to a 16-bit signed sample.
`ifdef DISCRETE_MIX_SATURATE_EN
    localparam logic signed [SUM_W-1:0] POS_LIM = SUM_W'(32767);
    localparam logic signed [SUM_W-1:0] NEG_LIM = -SUM_W'(32767);
    always_comb begin
        if (sum_q > POS_LIM) begin
            scaled = 16'sd32767;
        end else if (sum_q < NEG_LIM) begin
            scaled = -16'sd32767;
        end else begin
            scaled = 16'(sum_q);
        end
    end
`else
    always_comb begin
        scaled = 16'(sum_q >>> LOG2_CH);
    end
`endif

    // Align the 16-bit sample's MSB with the output MSB.
    if (OUT_WIDTH <= 16) begin : g_out_narrow
        always_comb out_d = scaled[15 -: OUT_WIDTH];
    end else begin : g_out_wide
        always_comb out_d = {scaled, (OUT_WIDTH-16)'(0)};
    end

    // Channel state, phase accumulators and the mix register advance on ticks only.
    // NOTE: the per-channel arrays are plain flops, so they are cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHANNELS; k++) begin
                state_q[k] <= IDLE;
                env_q[k]   <= '0;
                phase_q[k] <= '0;
            end
            sum_q     <= '0;
            sum_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            sum_valid <= audio_clk_en;
            if (audio_clk_en) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    state_q[k] <= state_d[k];
                    env_q[k]   <= env_d[k];
                    phase_q[k] <= phase_q[k] + freq_inc[16*k +: 16];
                end
                sum_q <= sum_d;
            end
        end
    end

    // Output stage: present the scaled mix one clk after the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= sum_valid;
            if (sum_valid) begin
                out <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_discrete_gated_tone_mixer.sv
// Testbench for discrete_gated_tone_mixer: directed scenarios plus random
// stimulus, scored against an envelope/oscillator reference model.
module tb_discrete_gated_tone_mixer;

    localparam int CH   = 2;
    localparam int OW   = 16;
    localparam int AS   = 1;
    localparam int RS   = 1;
    localparam int LOG2 = $clog2(CH);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 audio_clk_en = 1'b0;
    logic [CH-1:0]        gate = '0;
    logic [16*CH-1:0]     freq_inc = '0;
    logic [CH-1:0]        active;
    logic signed [OW-1:0] out;
    logic                 out_valid;

    discrete_gated_tone_mixer #(
        .CLOCK_RATE   (48000000),
        .SAMPLE_RATE  (48000),
        .CHANNELS     (CH),
        .OUT_WIDTH    (OW),
        .ATTACK_SHIFT (AS),
        .RELEASE_SHIFT(RS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_clk_en(audio_clk_en),
        .gate        (gate),
        .freq_inc    (freq_inc),
        .active      (active),
        .out         (out),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;
    int ticks  = 0;

    typedef struct {
        int value;
        int due;
    } exp_t;
    exp_t sb[$];

    // Reference model: envelope level and phase per channel.
    int            env_m   [CH];
    int            phase_m [CH];
    logic [CH-1:0] active_m = '0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < CH; k++) begin
            env_m[k]   = 0;
            phase_m[k] = 0;
        end
        active_m = '0;
    endfunction

    // Mixed sample from the levels held before this tick.
    function automatic int model_mix();
        int sum = 0;
        for (int k = 0; k < CH; k++) begin
            sum += (phase_m[k] >= 32768) ? -env_m[k] : env_m[k];
        end
`ifdef DISCRETE_MIX_SATURATE_EN
        if (sum > 32767)  sum = 32767;
        if (sum < -32767) sum = -32767;
        return sum;
`else
        return sum >>> LOG2;
`endif
    endfunction

    // Envelope moves toward 32767 while gated, toward 0 otherwise; a zero step snaps.
    function automatic void model_update(input logic [CH-1:0] g, input logic [16*CH-1:0] f);
        int s;
        for (int k = 0; k < CH; k++) begin
            if (g[k]) begin
                s = (32767 - env_m[k]) >> AS;
                env_m[k] = (s == 0) ? 32767 : env_m[k] + s;
            end else begin
                s = env_m[k] >> RS;
                env_m[k] = (s == 0) ? 0 : env_m[k] - s;
            end
            phase_m[k]  = (phase_m[k] + int'(f[16*k +: 16])) % 65536;
            active_m[k] = (env_m[k] != 0);
        end
    endfunction

    // One clk of stimulus; en=1 makes that clk a tick.
    task automatic step(input logic [CH-1:0] g, input logic [16*CH-1:0] f, input bit en);
        @(negedge clk);
        gate         = g;
        freq_inc     = f;
        audio_clk_en = en;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            check("reset_out", int'(out), 0);
            check("reset_out_valid", int'(out_valid), 0);
            check("reset_active", int'(active), 0);
        end else if (en) begin
            sb.push_back(exp_t'{model_mix(), cyc + 1});
            model_update(g, f);
            ticks++;
            check("active_tick", int'(active), int'(active_m));
        end else begin
            check("active_hold", int'(active), int'(active_m));
        end
    endtask

    // Scoreboard monitor: every out_valid pulse pops one expected sample.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                pulses++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    check("out", int'(out), e.value);
                    check("latency", cyc, e.due);
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16*CH-1:0] f;
        logic [CH-1:0]    g;
        int               p0;

        model_reset();

        // Reset held with gates high and strobes arriving.
        repeat (5) step('1, {16'h1234, 16'h0777}, 1'b1);
        step('0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Attack to hold, DC output.
        repeat (20) step(2'b01, '0, 1'b1);
        step(2'b01, '0, 1'b0);

        // Square wave on channel 0 in hold.
        repeat (12) step(2'b01, {16'h0000, 16'h4000}, 1'b1);

        // Release from 32767 for two ticks, retrigger at 8192, then full release.
        repeat (2) step(2'b00, '0, 1'b1);
        step(2'b01, '0, 1'b1);
        repeat (20) step(2'b00, '0, 1'b1);
        step(2'b00, '0, 1'b0);

        // Both channels to hold, phases aligned to 0: full-scale positive mix.
        repeat (20) step(2'b11, '0, 1'b1);
        f = '0;
        for (int k = 0; k < CH; k++) f[16*k +: 16] = 16'((65536 - phase_m[k]) % 65536);
        step(2'b11, f, 1'b1);
        step(2'b11, '0, 1'b1);
        step(2'b11, '0, 1'b0);
        check("mix_both_hold", int'(out), 32767);

        // Channel 1 to the negative half: the two cancel.
        step(2'b11, {16'h8000, 16'h0000}, 1'b1);
        step(2'b11, '0, 1'b1);
        step(2'b11, '0, 1'b0);
        check("mix_cancel", int'(out), 0);

        // Three consecutive ticks give three pulses.
        p0 = pulses;
        repeat (3) step(2'b10, {16'h2000, 16'h1000}, 1'b1);
        step(2'b10, '0, 1'b0);
        step(2'b10, '0, 1'b0);
        check("burst_pulses", pulses - p0, 3);

        // Asynchronous reset in the middle of an attack.
        repeat (8) step(2'b00, '0, 1'b1);
        repeat (3) step(2'b01, {16'h0000, 16'h3000}, 1'b1);
        step(2'b01, '0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_out", int'(out), 0);
        check("async_active", int'(active), 0);
        check("async_out_valid", int'(out_valid), 0);
        model_reset();
        step(2'b01, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(2'b01, '0, 1'b1);

        // Random gates, increments and strobe spacing.
        g = '0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(7) == 0) g[k] = ~g[k];
            end
            for (int k = 0; k < CH; k++) begin
                f[16*k +: 16] = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom);
            end
            step(g, f, 1'b1);
            repeat ($urandom_range(2)) step(g, f, 1'b0);
        end

        repeat (3) step('0, '0, 1'b0);
        check("scoreboard_empty", sb.size(), 0);
        check("pulse_count", pulses, ticks);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
